// File: rtl/param_ram.sv
// param_ram: single-port parameter RAM with a request/ready handshake.
//
// A request (memSrc = read, memDes = write, both = write) is taken only in
// IDLE. The address, write data and operation are captured on that edge,
// so the inputs may change freely while busy is high. Each access takes
// 2 + wait-count edges from the request edge to the ready pulse.
//
// Build option:
//   RAM_WAIT_EN  defined   -> WAIT_CYCLES wait states are added per access
//                undefined -> no wait states, fixed 2-edge latency
//
// Parameters:
//   DATA_W       word width in bits
//   ADDR_W       address width in bits
//   DEPTH        number of implemented words (1 .. 2**ADDR_W)
//   WAIT_CYCLES  wait states per access when RAM_WAIT_EN is defined (0..15)
//
// Ports:
//   CLK      in   clock; all state changes on its rising edge
//   RST      in   asynchronous active-high reset
//   memSrc   in   read request
//   memDes   in   write request (takes priority over memSrc)
//   AR       in   word address
//   CB       in   write data
//   memData  out  registered read data; holds the last read value
//   busy     out  high from the request edge until the ready edge
//   ready    out  one-cycle completion pulse
//   addrErr  out  high with ready when the completed access had AR >= DEPTH
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a request; the only state that accepts one
//   WAIT   | burning wait states; cnt_q counts down to 1
//   ACCESS | phase 0: memory read into rd_word_q
//          | phase 1: write commit / memData update, ready pulse

module param_ram #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 12,
   parameter int DEPTH       = 4096,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              memSrc,
   input  logic              memDes,
   input  logic [ADDR_W-1:0] AR,
   input  logic [DATA_W-1:0] CB,
   output logic [DATA_W-1:0] memData,
   output logic              busy,
   output logic              ready,
   output logic              addrErr
);

`ifdef RAM_WAIT_EN
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);
`else
   localparam logic [3:0] WAIT_CNT = 4'd0;
`endif

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic                acc_ph_q,    acc_ph_d;
   logic [3:0]          cnt_q,       cnt_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [DATA_W-1:0]   wdata_q,     wdata_d;
   logic                op_wr_q,     op_wr_d;
   logic [DATA_W-1:0]   mem_data_q,  mem_data_d;
   logic                busy_q,      busy_d;
   logic                ready_q,     ready_d;
   logic                addr_err_q,  addr_err_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word_q;
   logic [IDX_W-1:0]    mem_idx;
   logic                in_range;
   logic                mem_we;
   logic                mem_re;

   // One extra bit on both sides so DEPTH == 2**ADDR_W still compares cleanly.
   assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
   assign mem_idx  = addr_q[IDX_W-1:0];

   // Write commits only on the final ACCESS edge, so a reset that lands in
   // WAIT or ACCESS phase 0 drops the write before it touches the array.
   assign mem_re = (state_q == ACCESS) && !acc_ph_q;
   assign mem_we = (state_q == ACCESS) && acc_ph_q && op_wr_q && in_range;

   always_comb begin
      state_d    = state_q;
      acc_ph_d   = acc_ph_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      op_wr_d    = op_wr_q;
      mem_data_d = mem_data_q;
      busy_d     = busy_q;
      ready_d    = 1'b0;
      addr_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (memSrc || memDes) begin
               addr_d   = AR;
               wdata_d  = CB;
               op_wr_d  = memDes;
               busy_d   = 1'b1;
               acc_ph_d = 1'b0;
               if (WAIT_CNT != 4'd0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_CNT;
               end else begin
                  state_d = ACCESS;
               end
            end
         end

         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            if (!acc_ph_q) begin
               acc_ph_d = 1'b1;
            end else begin
               acc_ph_d   = 1'b0;
               state_d    = IDLE;
               busy_d     = 1'b0;
               ready_d    = 1'b1;
               addr_err_d = !in_range;
               if (!op_wr_q) begin
                  mem_data_d = in_range ? rd_word_q : '0;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            acc_ph_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         acc_ph_q   <= 1'b0;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         op_wr_q    <= 1'b0;
         mem_data_q <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_ph_q   <= acc_ph_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         op_wr_q    <= op_wr_d;
         mem_data_q <= mem_data_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Array and its read register carry no reset so they map onto RAM macros.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_idx] <= wdata_q;
      end
      if (mem_re) begin
         rd_word_q <= mem[mem_idx];
      end
   end

   assign memData = mem_data_q;
   assign busy    = busy_q;
   assign ready   = ready_q;
   assign addrErr = addr_err_q;

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4096, meaning number of implemented words (1 to 2^ADDR_W).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states per access when RAM_WAIT_EN is defined (0 to 15).
REQ-005 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port memSrc, input, 1, read request.
REQ-008 The block SHALL have port memDes, input, 1, write request.
REQ-009 The block SHALL have port AR, input, ADDR_W, word address.
REQ-010 The block SHALL have port CB, input, DATA_W, write data.
REQ-011 The block SHALL have port memData, output, DATA_W, registered read data.
REQ-012 The block SHALL have port busy, output, 1, high while a request is in progress.
REQ-013 The block SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-014 The block SHALL have port addrErr, output, 1, high with ready when the completed access had AR >= DEPTH.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and ACCESS; memory SHALL be DEPTH words of DATA_W bits, with no reset of contents.
REQ-016 In IDLE, a rising edge with memSrc or memDes high SHALL latch AR, CB and the op, set busy=1 and go to WAIT (wait count nonzero) or ACCESS.
REQ-017 Both memSrc and memDes high SHALL be treated as a write; the read is dropped.
REQ-018 Requests SHALL be ignored whenever state is not IDLE; latched AR and CB SHALL be unaffected by input changes.
REQ-019 In WAIT, a down-counter loaded with the wait count SHALL decrement each edge; at 1 it SHALL go to ACCESS.
REQ-020 In ACCESS, on the edge the block SHALL perform the write or update memData with the read word, pulse ready=1 for exactly one cycle, clear busy and return to IDLE.
REQ-021 Latency SHALL be 2 + wait count edges from the request edge to ready high; the next request SHALL be accepted on the edge after ready.
REQ-022 A write SHALL leave memData unchanged; memData SHALL hold the last read value indefinitely.
REQ-023 AR >= DEPTH SHALL suppress the write, return all-zero read data, and assert addrErr together with ready.
REQ-024 A read following a write to the same address SHALL return the new data.

Reset
REQ-025 RST high SHALL immediately force state IDLE, memData=0, busy=0, ready=0, addrErr=0 and counter=0, regardless of CLK.
REQ-026 Reset during WAIT or ACCESS SHALL abort the access; the pending write SHALL NOT reach memory, and no ready pulse SHALL follow.

Configuration
REQ-027 With macro RAM_WAIT_EN defined, the wait count SHALL be WAIT_CYCLES.
REQ-028 Without RAM_WAIT_EN, the wait count SHALL be 0: WAIT is never entered and latency is fixed at 2 edges.

Verification
REQ-029 No macro, DATA_W=16: write AR=0x005 CB=0xBEEF, then read 0x005 -> ready 2 edges after each request, memData=0xBEEF, addrErr=0.
REQ-030 RAM_WAIT_EN, WAIT_CYCLES=3: read request -> busy high 5 cycles, ready exactly 5 edges after request, one cycle wide.
REQ-031 memSrc and memDes both high with AR=0x010 CB=0x1234 -> write performed, memData unchanged; later read of 0x010 returns 0x1234.
REQ-032 DEPTH=1024, ADDR_W=12: write then read at AR=0x400 -> write suppressed, memData=0, addrErr pulses with ready.
REQ-033 RAM_WAIT_EN, WAIT_CYCLES=4: write 0x0AAA to 0x020, assert RST during WAIT, then read 0x020 -> prior contents, no ready during reset; outputs 0 while reset.
REQ-034 Toggle memSrc and AR while busy=1 -> extra requests ignored; completed access uses the originally latched address.
